// File: rtl/data_memory_access_unit.sv
// Memory-stage data access engine: req/ack handshake to a variable-latency data memory,
// pipeline stall generation, misalignment and bus-timeout detection with sticky error flags.
module data_memory_access_unit #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hFFFFFFFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUOutM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  ErrClr,
  output logic                  BusErr,
  output logic                  MisalignErr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  mis_err_q, mis_err_d;

  logic acc;
  logic aligned;
  logic set_bus;
  logic set_mis;

  assign acc     = MemReadM | MemWriteM;
  assign aligned = (ALUOutM[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    set_bus = 1'b0;
    set_mis = 1'b0;
    StallM  = 1'b0;
    case (state_q)
      IDLE: begin
        StallM = acc & aligned;
        if (acc && aligned) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = ALUOutM;
          wdata_d = WriteDataM;
        end else if (acc) begin
          set_mis = 1'b1;
        end
      end
      WAIT: begin
        StallM = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          set_bus = 1'b1;
          if (!we_q) rdata_d = TIMEOUT_DATA;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
      end
    endcase
    // A new error event wins over a simultaneous clear.
    bus_err_d = set_bus | (bus_err_q & ~ErrClr);
    mis_err_d = set_mis | (mis_err_q & ~ErrClr);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
      mis_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_err_q <= bus_err_d;
      mis_err_q <= mis_err_d;
    end
  end

  assign ReadDataM   = rdata_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign BusErr      = bus_err_q;
  assign MisalignErr = mis_err_q;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Directed bench for data_memory_access_unit: load/store handshakes, timeout, misalignment,
// reset during an access, read/write priority and stray acks.
module tb_data_memory_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, ErrClr, BusErr, MisalignErr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  data_memory_access_unit dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ErrClr(ErrClr), .BusErr(BusErr), .MisalignErr(MisalignErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    int stalls;
    logic stable;

    RST = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    mem_rdata = '0; mem_ack = 1'b0; ErrClr = 1'b0;
    step(); step();
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_errs", {30'b0, BusErr, MisalignErr}, 32'd0);
    chk("rst_stall", {31'b0, StallM}, 32'd0);
    RST = 1'b0;
    step();

    // Load with ack on the first WAIT cycle
    MemReadM = 1'b1; ALUOutM = 32'h100;
    #1 chk("t1_stall_idle", {31'b0, StallM}, 32'd1);
    step();
    chk("t1_req_wait", {31'b0, mem_req}, 32'd1);
    chk("t1_we_wait", {31'b0, mem_we}, 32'd0);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_stall_wait", {31'b0, StallM}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("t1_req_done", {31'b0, mem_req}, 32'd0);
    chk("t1_rdata", ReadDataM, 32'hCAFEF00D);
    chk("t1_stall_done", {31'b0, StallM}, 32'd0);
    MemReadM = 1'b0;
    step();
    chk("t1_req_idle", {31'b0, mem_req}, 32'd0);

    // Store acked on the fifth WAIT cycle
    MemWriteM = 1'b1; ALUOutM = 32'h204; WriteDataM = 32'h12345678;
    #1 stalls = StallM ? 1 : 0;
    stable = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      step();
      if (StallM) stalls++;
      if (!(mem_req && mem_we && mem_addr == 32'h204 && mem_wdata == 32'h12345678)) stable = 1'b0;
      if (w == 5) mem_ack = 1'b1;
    end
    chk("t2_req_stable", {31'b0, stable}, 32'd1);
    step();
    mem_ack = 1'b0;
    chk("t2_stall_done", {31'b0, StallM}, 32'd0);
    chk("t2_stall_cycles", stalls, 32'd6);
    chk("t2_rdata_held", ReadDataM, 32'hCAFEF00D);
    chk("t2_req_done", {31'b0, mem_req}, 32'd0);
    MemWriteM = 1'b0;
    step();

    // Load with no ack: timeout after 16 WAIT cycles
    MemReadM = 1'b1; ALUOutM = 32'h300;
    step();
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    chk("t3_wait_cycles", n, 32'd16);
    chk("t3_req", {31'b0, mem_req}, 32'd0);
    chk("t3_buserr", {31'b0, BusErr}, 32'd1);
    chk("t3_rdata", ReadDataM, 32'hFFFFFFFF);
    chk("t3_stall_done", {31'b0, StallM}, 32'd0);
    MemReadM = 1'b0;
    step();
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    chk("t3_buserr_clr", {31'b0, BusErr}, 32'd0);

    // Misaligned load with ErrClr in the same cycle
    MemReadM = 1'b1; ALUOutM = 32'h102; ErrClr = 1'b1;
    #1 chk("t4_stall", {31'b0, StallM}, 32'd0);
    step();
    chk("t4_req", {31'b0, mem_req}, 32'd0);
    chk("t4_mis_set", {31'b0, MisalignErr}, 32'd1);
    step();
    chk("t4_mis_prio", {31'b0, MisalignErr}, 32'd1);
    MemReadM = 1'b0;
    step();
    ErrClr = 1'b0;
    chk("t4_mis_clr", {31'b0, MisalignErr}, 32'd0);

    // Reset in the third WAIT cycle
    MemReadM = 1'b1; ALUOutM = 32'h100;
    step(); step(); step();
    chk("t5_req_wait3", {31'b0, mem_req}, 32'd1);
    RST = 1'b1; MemReadM = 1'b0;
    step();
    RST = 1'b0;
    chk("t5_req", {31'b0, mem_req}, 32'd0);
    chk("t5_stall", {31'b0, StallM}, 32'd0);
    chk("t5_rdata", ReadDataM, 32'h0);
    chk("t5_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("t5_late_ack_rdata", ReadDataM, 32'h0);
    chk("t5_late_ack_req", {31'b0, mem_req}, 32'd0);

    // Read and write together: write wins
    MemReadM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h40; WriteDataM = 32'hA5A5A5A5;
    step();
    chk("t6_we", {31'b0, mem_we}, 32'd1);
    chk("t6_addr", mem_addr, 32'h40);
    chk("t6_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    chk("t6_rdata_held", ReadDataM, 32'h0);
    MemReadM = 1'b0; MemWriteM = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t6_stray_req", {31'b0, mem_req}, 32'd0);
    MemReadM = 1'b1; ALUOutM = 32'h80;
    step();
    chk("t6_after_stray_req", {31'b0, mem_req}, 32'd1);
    chk("t6_after_stray_we", {31'b0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    step();
    mem_ack = 1'b0;
    chk("t6_read_rdata", ReadDataM, 32'h11223344);
    MemReadM = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
